scan_sequencer: RTL and testbench

Round-robin channel scanner that generates the 3-bit select code consumed directly by the 3-to-8 decoder stage. It steps through the channels enabled in an 8-bit mask, holds each for a programmable dwell, and inserts a blanking gap between channels to prevent ghosting on multiplexed outputs such as display digits or LED rows. Outputs are registered so the downstream decoder sees glitch-free codes.

---
 rtl/scan_pkg.sv | 6 +
 rtl/scan_next_ch.sv | 31 +++
 rtl/scan_sequencer.sv | 96 +++++++++
 tb/tb_scan_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and channel constants for the scan sequencer.
package scan_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} scan_state_t;
endpackage

// File: rtl/scan_next_ch.sv
// scan_next_ch: picks the lowest enabled channel above cur, wrapping to the lowest overall.
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap,
    output logic              none
);
    logic [SEL_W-1:0] lo, hi;
    logic             hit;

    // Descending scan so the last match written is the lowest index.
    always_comb begin
        lo  = '0;
        hi  = '0;
        hit = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k]) lo = SEL_W'(k);
            if (mask[k] && k > int'(cur)) begin
                hi  = SEL_W'(k);
                hit = 1'b1;
            end
        end
    end

    assign nxt  = hit ? hi : lo;
    assign wrap = !hit;
    assign none = (mask == '0);
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: round-robin channel scanner with per-channel dwell and blanking gap.
module scan_sequencer #(
    parameter int DWELL = 100,
    parameter int BLANK = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [scan_pkg::NUM_CH-1:0] mask,
    output logic [scan_pkg::SEL_W-1:0]  sel,
    output logic                        sel_valid,
    output logic                        frame_done
);
    import scan_pkg::scan_state_t;
    import scan_pkg::IDLE;
    import scan_pkg::ACTIVE;
    import scan_pkg::SEL_W;

    localparam int MX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW = $clog2(MX + 1);

    scan_state_t      state_q;
    logic [SEL_W-1:0] sel_q;
    logic             valid_q, fd_q;
    logic [CW-1:0]    cnt_q;
    logic [SEL_W-1:0] nxt, cur;
    logic             wrap, none, at_last;

    // From IDLE, searching above the top index yields the lowest enabled channel.
    assign cur     = (state_q == IDLE) ? SEL_W'(scan_pkg::NUM_CH - 1) : sel_q;
    assign at_last = cnt_q == ((state_q == ACTIVE) ? CW'(DWELL - 1) : CW'(BLANK - 1));

    scan_next_ch u_next (
        .mask (mask),
        .cur  (cur),
        .nxt  (nxt),
        .wrap (wrap),
        .none (none)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
            cnt_q   <= '0;
        end else if (!en) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            fd_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            fd_q  <= 1'b0;
            cnt_q <= cnt_q + CW'(1);
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!none) begin
                        state_q <= ACTIVE;
                        sel_q   <= nxt;
                        valid_q <= 1'b1;
                    end
                end
                ACTIVE: if (at_last) begin
                    cnt_q <= '0;
                    if (BLANK > 0) begin
                        state_q <= scan_pkg::BLANK;
                        valid_q <= 1'b0;
                    end else if (none) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else begin
                        sel_q <= nxt;
                        fd_q  <= wrap;
                    end
                end
                default: if (at_last) begin
                    cnt_q <= '0;
                    if (none) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= ACTIVE;
                        sel_q   <= nxt;
                        valid_q <= 1'b1;
                        fd_q    <= wrap;
                    end
                end
            endcase
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = valid_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: scoreboard bench; expected {valid,sel,frame_done} per cycle is queued up front.
module tb_scan_sequencer;
    localparam int D = 4;
    localparam int B = 1;

    logic       clk = 1'b0;
    logic       rst_n, en, en2;
    logic [7:0] mask, mask2;
    logic [2:0] sel, sel2;
    logic       sel_valid, frame_done, sel_valid2, frame_done2;
    logic [4:0] obs, obs2, e;
    logic [4:0] q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    assign obs  = {sel_valid, sel, frame_done};
    assign obs2 = {sel_valid2, sel2, frame_done2};

    scan_sequencer #(.DWELL(D), .BLANK(B)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mask(mask),
        .sel(sel), .sel_valid(sel_valid), .frame_done(frame_done)
    );

    scan_sequencer #(.DWELL(1), .BLANK(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .mask(mask2),
        .sel(sel2), .sel_valid(sel_valid2), .frame_done(frame_done2)
    );

    always #5 clk = ~clk;

    task automatic push_ch(input logic [2:0] ch, input logic fd, input int d, input int b);
        for (int i = 0; i < d; i++) q.push_back({1'b1, ch, (i == 0) ? fd : 1'b0});
        for (int i = 0; i < b; i++) q.push_back({1'b0, ch, 1'b0});
    endtask

    task automatic go_idle();
        en = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (obs[4] !== 1'b0 || obs[0] !== 1'b0)
            $display("FAIL go_idle got valid=%b fd=%b exp valid=0 fd=0", obs[4], obs[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if (obs !== 5'b0) $display("FAIL reset_init got %b exp 00000", obs);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        en = 1'b1; mask = 8'hFF;
        @(posedge clk); #1;
        total_cnt++;
        if (obs !== {1'b1, 3'd0, 1'b0}) $display("FAIL reset_start got %b exp 10000", obs);
        else pass_cnt++;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (obs !== 5'b0) $display("FAIL reset_mid got %b exp 00000", obs);
        else pass_cnt++;
        en = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (obs !== 5'b0) $display("FAIL reset_idle%0d got %b exp 00000", i, obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_scan();
        for (int c = 0; c < 8; c++) push_ch(3'(c), 1'b0, D, B);
        push_ch(3'd0, 1'b1, D, B);
        push_ch(3'd1, 1'b0, D, B);
        en = 1'b1; mask = 8'hFF;
        for (int i = 0; q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = q.pop_front();
            total_cnt++;
            if (obs !== e) $display("FAIL full_scan cyc %0d got %b exp %b", i, obs, e);
            else pass_cnt++;
        end
        go_idle();
    endtask

    task automatic test_sparse();
        push_ch(3'd0, 1'b0, D, B); push_ch(3'd2, 1'b0, D, B); push_ch(3'd7, 1'b0, D, B);
        push_ch(3'd0, 1'b1, D, B); push_ch(3'd2, 1'b0, D, B); push_ch(3'd7, 1'b0, D, B);
        push_ch(3'd0, 1'b1, D, B);
        en = 1'b1; mask = 8'b1000_0101;
        for (int i = 0; q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = q.pop_front();
            total_cnt++;
            if (obs !== e) $display("FAIL sparse cyc %0d got %b exp %b", i, obs, e);
            else pass_cnt++;
        end
        go_idle();
    endtask

    task automatic test_mask_change();
        push_ch(3'd0, 1'b0, D, B); push_ch(3'd2, 1'b0, D, B);
        push_ch(3'd3, 1'b0, D, B); push_ch(3'd3, 1'b1, D, B);
        en = 1'b1; mask = 8'h05;
        for (int i = 0; q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = q.pop_front();
            total_cnt++;
            if (obs !== e) $display("FAIL mask_change cyc %0d got %b exp %b", i, obs, e);
            else pass_cnt++;
            if (i == 6) mask = 8'h08;
        end
        go_idle();
    endtask

    task automatic test_mask_zero();
        push_ch(3'd2, 1'b0, D, B);
        for (int i = 0; i < 3; i++) q.push_back({1'b0, 3'd2, 1'b0});
        push_ch(3'd4, 1'b0, D, B); push_ch(3'd5, 1'b0, D, B); push_ch(3'd4, 1'b1, D, B);
        en = 1'b1; mask = 8'h0C;
        for (int i = 0; q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = q.pop_front();
            total_cnt++;
            if (obs !== e) $display("FAIL mask_zero cyc %0d got %b exp %b", i, obs, e);
            else pass_cnt++;
            if (i == 4) mask = 8'h00;
            if (i == 7) mask = 8'h30;
        end
        go_idle();
    endtask

    task automatic test_en_drop();
        q.push_back({1'b1, 3'd6, 1'b0}); q.push_back({1'b1, 3'd6, 1'b0});
        q.push_back({1'b0, 3'd6, 1'b0}); q.push_back({1'b0, 3'd6, 1'b0});
        push_ch(3'd6, 1'b0, D, B); push_ch(3'd6, 1'b1, D, B);
        en = 1'b1; mask = 8'h40;
        for (int i = 0; q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = q.pop_front();
            total_cnt++;
            if (obs !== e) $display("FAIL en_drop cyc %0d got %b exp %b", i, obs, e);
            else pass_cnt++;
            if (i == 1) en = 1'b0;
            if (i == 3) en = 1'b1;
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        push_ch(3'd0, 1'b0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            push_ch(3'd4, 1'b0, 1, 0);
            push_ch(3'd0, 1'b1, 1, 0);
        end
        en2 = 1'b1; mask2 = 8'h11;
        for (int i = 0; q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = q.pop_front();
            total_cnt++;
            if (obs2 !== e) $display("FAIL back_to_back cyc %0d got %b exp %b", i, obs2, e);
            else pass_cnt++;
        end
        en2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mask = 8'h00; en2 = 1'b0; mask2 = 8'h00;
        test_reset();
        test_full_scan();
        test_sparse();
        test_mask_change();
        test_mask_zero();
        test_en_drop();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
